// File: rtl/dkong_input_cond.sv
// Input conditioner for the Donkey Kong CPU switch ports.
// Raw active-high host controls are synchronised, debounced and 4-way filtered.
// Coin presses are stretched to a pulse that lasts a fixed number of frames.
// The results are presented as three registered active-low switch bytes.
module dkong_input_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_TICKS   = 1024,
    parameter int COIN_FRAMES = 4
) (
    input  logic       I_CLK,
    input  logic       I_RST_n,
    input  logic [4:0] I_P1,
    input  logic [4:0] I_P2,
    input  logic       I_START1,
    input  logic       I_START2,
    input  logic       I_COIN,
    input  logic       I_VBL_n,
    output logic [7:0] O_SW1,
    output logic [7:0] O_SW2,
    output logic [7:0] O_SW3
);

    localparam int NB = 13;
    localparam int CW = $clog2(DEB_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_TICKS - 1);
    localparam logic [3:0]    COIN_LAST = 4'(COIN_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_WAIT
    } coin_state_t;

    // Raw bit order: p1[4:0], p2[4:0], start1, start2, coin.
    logic [NB-1:0]                  raw;
    logic [SYNC_STAGES-1:0][NB-1:0] sync_q;
    logic [NB-1:0]                  synced;
    logic [NB-1:0][CW-1:0]          cnt;
    logic [NB-1:0]                  deb;
    logic                           vbl_prev;
    logic                           frame_tick;
    logic                           dc_prev;
    coin_state_t                    state_q, state_n;
    logic [3:0]                     f_q, f_n;
    logic                           coin_out;

    assign raw        = {I_COIN, I_START2, I_START1, I_P2, I_P1};
    assign synced     = sync_q[SYNC_STAGES-1];
    assign frame_tick = vbl_prev & ~I_VBL_n;
    assign coin_out   = (state_q == ST_HOLD);

    // Opposing directions cancel each other; everything else passes through.
    function automatic logic [4:0] four_way(input logic [4:0] p);
        logic [4:0] q;
        q = p;
        if (p[0] && p[1]) q[1:0] = 2'b00;
        if (p[2] && p[3]) q[3:2] = 2'b00;
        return q;
    endfunction

    // Shift every raw bit through the synchroniser chain.
    always_ff @(posedge I_CLK or negedge I_RST_n) begin
        if (!I_RST_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Accept a new level only after it has differed from the stable one for DEB_TICKS clocks.
    always_ff @(posedge I_CLK or negedge I_RST_n) begin
        if (!I_RST_n) begin
            cnt <= '0;
            deb <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (synced[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= synced[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Remember previous vblank and debounced coin levels for edge detection.
    always_ff @(posedge I_CLK or negedge I_RST_n) begin
        if (!I_RST_n) begin
            vbl_prev <= 1'b1;
            dc_prev  <= 1'b0;
        end else begin
            vbl_prev <= I_VBL_n;
            dc_prev  <= deb[12];
        end
    end

    // Coin FSM state and frame counter registers.
    always_ff @(posedge I_CLK or negedge I_RST_n) begin
        if (!I_RST_n) begin
            state_q <= ST_IDLE;
            f_q     <= '0;
        end else begin
            state_q <= state_n;
            f_q     <= f_n;
        end
    end

    // Coin FSM: one frame-counted pulse per insertion, then wait for release.
    always_comb begin
        state_n = state_q;
        f_n     = f_q;
        case (state_q)
            ST_IDLE: begin
                if (deb[12] && !dc_prev) begin
                    state_n = ST_HOLD;
                    f_n     = '0;
                end
            end
            ST_HOLD: begin
                if (frame_tick) begin
                    f_n = f_q + 4'd1;
                    if (f_q == COIN_LAST) state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!deb[12]) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Registered active-low switch bytes; unused bits read as released.
    always_ff @(posedge I_CLK or negedge I_RST_n) begin
        if (!I_RST_n) begin
            O_SW1 <= 8'hFF;
            O_SW2 <= 8'hFF;
            O_SW3 <= 8'hFF;
        end else begin
            O_SW1 <= ~{3'b000, four_way(deb[4:0])};
            O_SW2 <= ~{3'b000, four_way(deb[9:5])};
            O_SW3 <= ~{coin_out, 3'b000, deb[11], deb[10], 2'b00};
        end
    end

endmodule

// File: tb/tb_dkong_input_cond.sv
// Self-checking bench for dkong_input_cond.
// A behavioural model predicts all three bytes every clock; directed tests add
// hand-computed literal checks on latency, glitch rejection, 4-way and coin pulses.
module tb_dkong_input_cond;

    localparam int SYNC      = 2;
    localparam int DEB       = 16;
    localparam int COIN      = 4;
    localparam int FRAME_LEN = 24;
    localparam int VBL_LOW   = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] p1 = '0;
    logic [4:0] p2 = '0;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic       coin = 1'b0;
    logic       vbl;
    logic       vbl_run = 1'b0;
    logic [7:0] sw1, sw2, sw3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dkong_input_cond #(
        .SYNC_STAGES(SYNC),
        .DEB_TICKS  (DEB),
        .COIN_FRAMES(COIN)
    ) dut (
        .I_CLK   (clk),
        .I_RST_n (rst_n),
        .I_P1    (p1),
        .I_P2    (p2),
        .I_START1(start1),
        .I_START2(start2),
        .I_COIN  (coin),
        .I_VBL_n (vbl),
        .O_SW1   (sw1),
        .O_SW2   (sw2),
        .O_SW3   (sw3)
    );

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [12:0] raw_q[$];
    bit [12:0] s_hist[$];
    bit [12:0] m_d;
    bit        m_dcp, m_vprev, m_pulsing, m_need_rel;
    int        m_frames;
    logic [7:0] exp1 = 8'hFF, exp2 = 8'hFF, exp3 = 8'hFF;

    function automatic logic [7:0] pmap(input logic [4:0] p);
        logic [4:0] q;
        q = p;
        if (p[0] && p[1]) q[1:0] = 2'b00;
        if (p[2] && p[3]) q[3:2] = 2'b00;
        return ~{3'b000, q};
    endfunction

    task automatic modelReset();
        raw_q = {};
        repeat (SYNC) raw_q.push_back(13'd0);
        s_hist = {};
        repeat (DEB) s_hist.push_back(13'd0);
        m_d = '0;
        m_dcp = 1'b0;
        m_vprev = 1'b1;
        m_pulsing = 1'b0;
        m_need_rel = 1'b0;
        m_frames = 0;
        exp1 = 8'hFF;
        exp2 = 8'hFF;
        exp3 = 8'hFF;
    endtask

    task automatic modelStep();
        bit [12:0] s;
        bit [12:0] dummy;
        bit        tick;
        bit        all_diff;
        exp1 = pmap(m_d[4:0]);
        exp2 = pmap(m_d[9:5]);
        exp3 = ~{m_pulsing, 3'b000, m_d[11], m_d[10], 2'b00};
        tick = m_vprev && !vbl;
        if (m_pulsing) begin
            if (tick) begin
                m_frames++;
                if (m_frames == COIN) begin
                    m_pulsing = 1'b0;
                    m_need_rel = 1'b1;
                end
            end
        end else if (m_need_rel) begin
            if (!m_d[12]) m_need_rel = 1'b0;
        end else if (m_d[12] && !m_dcp) begin
            m_pulsing = 1'b1;
            m_frames = 0;
        end
        m_dcp = m_d[12];
        m_vprev = vbl;
        raw_q.push_back({coin, start2, start1, p2, p1});
        s = raw_q.pop_front();
        s_hist.push_back(s);
        dummy = s_hist.pop_front();
        for (int i = 0; i < 13; i++) begin
            all_diff = 1'b1;
            foreach (s_hist[k]) if (s_hist[k][i] == m_d[i]) all_diff = 1'b0;
            if (all_diff) m_d[i] = s[i];
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep();
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("sw1_model", sw1, exp1);
            checkOutput("sw2_model", sw2, exp2);
            checkOutput("sw3_model", sw3, exp3);
        end
    end

    // Vertical blank generator.
    initial begin
        int phase;
        phase = 0;
        vbl = 1'b1;
        forever begin
            @(negedge clk);
            if (vbl_run) begin
                phase = (phase + 1) % FRAME_LEN;
                vbl = (phase >= VBL_LOW);
            end else begin
                vbl = 1'b1;
            end
        end
    end

    // Pulse monitor: counts vblank falls seen while the coin bit is asserted.
    bit tick_tb = 1'b0;
    bit vbl_last = 1'b1;
    bit in_pulse = 1'b0;
    int pulse_ticks = 0;
    int pulse_log[$];

    initial begin
        forever begin
            @(posedge clk);
            tick_tb = vbl_last && !vbl;
            vbl_last = vbl;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sw3[7] === 1'b0) begin
                if (!in_pulse) begin
                    in_pulse = 1'b1;
                    pulse_ticks = 0;
                end
                if (tick_tb) pulse_ticks++;
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                pulse_log.push_back(pulse_ticks);
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] np1, input logic [4:0] np2,
                                 input logic ns1, input logic ns2, input logic nc);
        @(negedge clk);
        p1 = np1;
        p2 = np2;
        start1 = ns1;
        start2 = ns2;
        coin = nc;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        p1 = '0;
        p2 = '0;
        start1 = 1'b0;
        start2 = 1'b0;
        coin = 1'b0;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(SYNC + DEB + 4);
    endtask

    initial begin
        // Reset with every input pressed.
        p1 = 5'h1F; p2 = 5'h1F; start1 = 1'b1; start2 = 1'b1; coin = 1'b1;
        waitCycles(3);
        checkOutput("t1_rst_sw1", sw1, 8'hFF);
        checkOutput("t1_rst_sw2", sw2, 8'hFF);
        checkOutput("t1_rst_sw3", sw3, 8'hFF);
        rst_n = 1'b1;
        waitCycles(SYNC + DEB);
        checkOutput("t1_hold_sw1", sw1, 8'hFF);
        checkOutput("t1_hold_sw3", sw3, 8'hFF);
        waitCycles(1);
        checkOutput("t1_all_sw1", sw1, 8'hEF);
        checkOutput("t1_all_sw2", sw2, 8'hEF);
        checkOutput("t1_all_sw3", sw3, 8'hF3);

        // Latency of a single press.
        applyReset();
        applyStimulus(5'b00001, 5'b00000, 1'b0, 1'b0, 1'b0);
        waitCycles(SYNC + DEB);
        checkOutput("t2_early_sw1", sw1, 8'hFF);
        waitCycles(1);
        checkOutput("t2_sw1", sw1, 8'hFE);
        checkOutput("t2_sw2", sw2, 8'hFF);
        checkOutput("t2_sw3", sw3, 8'hFF);

        // Glitch restarts the debounce count.
        applyReset();
        applyStimulus(5'h10, 5'h00, 1'b0, 1'b0, 1'b0);
        waitCycles(DEB - 1);
        p1 = 5'h00;
        waitCycles(1);
        p1 = 5'h10;
        waitCycles(SYNC + 1);
        checkOutput("t3_glitch_sw1", sw1, 8'hFF);
        waitCycles(DEB - 1);
        checkOutput("t3_late_sw1", sw1, 8'hFF);
        waitCycles(1);
        checkOutput("t3_jump_sw1", sw1, 8'hEF);

        // Opposing-direction suppression.
        applyReset();
        applyStimulus(5'h00, 5'b00011, 1'b0, 1'b0, 1'b0);
        waitCycles(SYNC + DEB + 3);
        checkOutput("t4_rl_sw2", sw2, 8'hFF);
        applyStimulus(5'h00, 5'b01101, 1'b0, 1'b0, 1'b0);
        waitCycles(SYNC + DEB + 3);
        checkOutput("t4_ud_sw2", sw2, 8'hFE);

        // Coin pulse stretching.
        applyReset();
        vbl_run = 1'b1;
        pulse_log = {};
        applyStimulus(5'h00, 5'h00, 1'b0, 1'b0, 1'b1);
        waitCycles(10 * FRAME_LEN);
        checkCount("t5_pulses_held", pulse_log.size(), 1);
        checkOutput("t5_held_sw3", sw3, 8'hFF);
        applyStimulus(5'h00, 5'h00, 1'b0, 1'b0, 1'b0);
        waitCycles(SYNC + DEB + 4);
        applyStimulus(5'h00, 5'h00, 1'b0, 1'b0, 1'b1);
        waitCycles(6 * FRAME_LEN);
        applyStimulus(5'h00, 5'h00, 1'b0, 1'b0, 1'b0);
        waitCycles(SYNC + DEB + 4);
        applyStimulus(5'h00, 5'h00, 1'b0, 1'b0, 1'b1);
        waitCycles(DEB + 2);
        applyStimulus(5'h00, 5'h00, 1'b0, 1'b0, 1'b0);
        waitCycles(6 * FRAME_LEN);
        checkCount("t5_pulses_total", pulse_log.size(), 3);
        foreach (pulse_log[i]) checkCount("t5_pulse_frames", pulse_log[i], COIN);

        // Starts, then reset in the middle of a coin pulse.
        applyReset();
        applyStimulus(5'h00, 5'h00, 1'b1, 1'b1, 1'b0);
        waitCycles(SYNC + DEB + 3);
        checkOutput("t6_starts_sw3", sw3, 8'hF3);
        applyStimulus(5'h00, 5'h00, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3 * DEB && sw3 !== 8'h73; k++) @(negedge clk);
        checkOutput("t6_hold_sw3", sw3, 8'h73);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t6_async_sw3", sw3, 8'hFF);
        coin = 1'b0;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(SYNC + DEB + 3);
        checkOutput("t6_after_sw3", sw3, 8'hF3);
        waitCycles(6 * FRAME_LEN);
        checkOutput("t6_idle_sw3", sw3, 8'hF3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
